// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_if
// Description : Operand/result handshake bundle for nibble_serial_adder.
//               slave  modport - seen by the adder
//               master modport - seen by the operand producer / result consumer
//   in_valid/in_ready   : operand request / adder can accept (IDLE only)
//   a, b, cin           : operands (W = 4*NIBBLES bits) and carry-in
//   acc_en, acc_clr     : use/write accumulator as operand B, clear accumulator
//   out_valid/out_ready : result valid / consumer takes result
//   sum, cout, ovf, acc : result, carry out, signed overflow, accumulator
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         acc_en;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [W-1:0] acc;

    modport slave (
        input  in_valid, a, b, cin, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, sum, cout, ovf, acc
    );

    modport master (
        output in_valid, a, b, cin, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, acc
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Nibble-serial W-bit adder with optional chained accumulator.
//               A 4-bit adder stage is reused once per nibble, LSB first,
//               with the carry registered between nibbles. When acc_en is
//               set at accept time the accumulator replaces operand B and
//               the full result is written back to it.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - nibble_serial_adder_if.slave (handshake, operands,
//                       result, accumulator)
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  wire                         clk,
    input  wire                         rst_n,
    nibble_serial_adder_if.slave        bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_bop;
    logic            r_acc_en;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;
    logic [W-1:0]    r_acc;

    logic            w_accept;
    logic            w_last;
    logic [IDXW+1:0] w_base;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [4:0]      w_nib_sum;
    logic [3:0]      w_low3;
    logic [W-1:0]    w_sum_nxt;

    // ------------------------------------------------------------------
    // FSM: state register and next-state decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared 4-bit adder stage
    // ------------------------------------------------------------------
    always_comb begin
        w_last    = (r_idx == c_last_idx);
        w_base    = {r_idx, 2'b00};
        w_a_nib   = r_a[w_base +: 4];
        w_b_nib   = r_bop[w_base +: 4];
        w_nib_sum = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
        // Bit 3 of the low-three-bit sum is the carry into the nibble MSB;
        // on the last nibble that is the carry into bit W-1.
        w_low3    = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, r_carry};
        // Result with the current nibble merged in, so the accumulator can
        // take the complete value on the same edge as the last nibble.
        w_sum_nxt = r_sum;
        w_sum_nxt[w_base +: 4] = w_nib_sum[3:0];
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_bop    <= '0;
            r_acc_en <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_acc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.acc_clr) begin
                        r_acc <= '0;
                    end
                    if (w_accept) begin
                        r_a      <= bus.a;
                        // A simultaneous clear wins over the old accumulator.
                        if (bus.acc_en) begin
                            r_bop <= bus.acc_clr ? '0 : r_acc;
                        end else begin
                            r_bop <= bus.b;
                        end
                        r_acc_en <= bus.acc_en;
                        r_carry  <= bus.cin;
                        r_idx    <= '0;
                    end
                end
                S_ADD: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_nib_sum[4];
                    if (w_last) begin
                        r_cout <= w_nib_sum[4];
                        r_ovf  <= w_low3[3] ^ w_nib_sum[4];
                        r_idx  <= '0;
                        if (r_acc_en) begin
                            r_acc <= w_sum_nxt;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ; // HOLD: everything stable
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: handshake flags decoded from the state register only
    // ------------------------------------------------------------------
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.acc       = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Self-checking bench for nibble_serial_adder (NIBBLES=4).
//               Table of directed operations plus hand-written sequences
//               for backpressure and reset in the middle of an add.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst_n;

    nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         acc_en;
        logic         acc_clr;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        logic [W-1:0] exp_acc;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one operation, accept it, then wait (bounded) for out_valid.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic acc_en, input logic acc_clr,
                            input string tag);
        int lat;
        check({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.acc_en   = acc_en;
        bus.acc_clr  = acc_clr;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Changes after capture must have no effect.
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.acc_en   = ~acc_en;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.cin      = ~cin;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(NIBBLES));
    endtask

    // Pulse out_ready for one cycle and confirm return to IDLE.
    task automatic finish_op(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid after release"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready after release"},  32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        // a, b, cin, acc_en, acc_clr, exp_sum, exp_cout, exp_ovf, exp_acc
        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h0000};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[5] = '{16'h0010, 16'hABCD, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0010};
        vecs[6] = '{16'h0020, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'h0030, 1'b0, 1'b0, 16'h0030};
        vecs[7] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h0030};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset sum",       32'(bus.sum),       32'd0);
        check("reset acc",       32'(bus.acc),       32'd0);
        check("reset cout",      32'(bus.cout),      32'd0);
        check("reset ovf",       32'(bus.ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].acc_en, vecs[i].acc_clr, tag);
            check({tag, " sum"},      32'(bus.sum),      32'(vecs[i].exp_sum));
            check({tag, " cout"},     32'(bus.cout),     32'(vecs[i].exp_cout));
            check({tag, " ovf"},      32'(bus.ovf),      32'(vecs[i].exp_ovf));
            check({tag, " acc"},      32'(bus.acc),      32'(vecs[i].exp_acc));
            check({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
            finish_op(tag);
        end

        // Backpressure: HOLD ignores in_valid and acc_clr.
        start_op(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, "bp");
        bus.in_valid = 1'b1;
        bus.acc_clr  = 1'b1;
        bus.acc_en   = 1'b1;
        bus.a        = 16'h5555;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp c%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp c%0d in_ready", c),  32'(bus.in_ready),  32'd0);
            check($sformatf("bp c%0d sum", c),       32'(bus.sum),       32'h0300);
            check($sformatf("bp c%0d acc", c),       32'(bus.acc),       32'h0030);
        end
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.acc_en   = 1'b0;
        finish_op("bp");
        @(posedge clk);
        #1;
        check("bp nothing captured", 32'(bus.in_ready), 32'd1);
        check("bp acc kept",         32'(bus.acc),      32'h0030);

        // Reset in the middle of an add: outputs clear without a clock edge.
        bus.a        = 16'hFFFF;
        bus.b        = 16'h0001;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst mid sum",       32'(bus.sum),       32'd0);
        check("rst mid acc",       32'(bus.acc),       32'd0);
        check("rst mid cout",      32'(bus.cout),      32'd0);
        check("rst mid ovf",       32'(bus.ovf),       32'd0);
        check("rst mid out_valid", 32'(bus.out_valid), 32'd0);
        check("rst mid in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, "post");
        check("post sum", 32'(bus.sum), 32'h0007);
        check("post acc", 32'(bus.acc), 32'h0000);
        finish_op("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Nibble-serial multi-word adder and accumulator feeding the neural-network summation path. It accepts two W-bit operands over a valid/ready handshake and adds them one 4-bit nibble per clock, LSB nibble first. The carry is registered between nibbles, exactly as a single 4-bit full-adder stage is reused across words. An optional internal accumulator replaces operand B, so dot-product partial sums can be chained without external storage.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand; W = 4*NIBBLES; legal range 1..16
- Clk  in  1  single clock; all state updates on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- InValid  in  1  operand request
- InReady  out  1  block can accept operands (high only in IDLE)
- A  in  W  operand A, unsigned or two's complement
- B  in  W  operand B; ignored when AccEn=1
- Cin  in  1  carry into nibble 0
- AccEn  in  1  use accumulator as operand B and write result back to accumulator
- AccClr  in  1  clear accumulator; honoured only in IDLE
- OutValid  out  1  result valid
- OutReady  in  1  consumer takes result
- Sum  out  W  registered result
- Cout  out  1  carry out of MSB nibble
- Ovf  out  1  signed overflow, = carry into bit W-1 XOR carry out of bit W-1
- Acc  out  W  current accumulator value

## Operation
- States: IDLE, ADD, HOLD.
- **IDLE:** InReady=1, OutValid=0.
  - On InValid=1, at the edge: capture A; capture Bop = (AccEn ? Acc : B); capture AccEn; set carry reg = Cin; set idx=0; go to ADD.
  - AccClr=1 in IDLE clears Acc at the edge.
  - If AccClr, InValid and AccEn are all 1 in the same cycle, Bop = 0 and Acc is cleared. The clear wins for the captured operand.
- **ADD:** InReady=0. Each cycle computes {c4, s} = A[idx] + Bop[idx] + carry, where [idx] denotes nibble idx, in 5-bit arithmetic.
  - Writes s to Sum nibble idx; carry <= c4; idx <= idx+1.
  - On the final nibble (idx = NIBBLES-1): Cout <= c4; Ovf <= carry into bit W-1 XOR c4; if captured AccEn then Acc <= full result; go to HOLD.
  - Nibbles not yet written hold their previous values. Sum is only defined when OutValid=1.
- **HOLD:** OutValid=1; Sum, Cout, Ovf, Acc stable.
  - InValid and AccClr are ignored.
  - On OutReady=1, go to IDLE at the edge.
- Result is modulo 2^W. No saturation.
- AccClr outside IDLE has no effect.
- AccEn/B/A changes after capture have no effect.
- **Reset (Rst_n low, any state, including mid-ADD):** immediately go to IDLE; Sum=0, Cout=0, Ovf=0, Acc=0, OutValid=0, idx=0, carry reg=0. InReady=1 once in IDLE. The partial operation is discarded.

## Timing
- Accept at edge k (IDLE, InValid=1) -> ADD cycles k+1 .. k+NIBBLES -> OutValid=1 from edge k+NIBBLES.
- Latency is NIBBLES cycles from accept to OutValid.
- HOLD lasts ≥1 cycle. With OutReady tied high, throughput is one result per NIBBLES+2 cycles: accept, NIBBLES ADD, 1 HOLD, then IDLE.
- No combinational path from InValid to InReady, or from OutReady to OutValid. All outputs except InReady are registered. InReady is decoded from the state register.
- Acc updates on the same edge that OutValid rises.

## Test plan
- **Basic add, NIBBLES=4:** A=0x1234, B=0x0FCD, Cin=0 -> Sum=0x2201, Cout=0, Ovf=0. OutValid rises exactly 4 cycles after the accept edge.
- **Full carry ripple:** A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0. Repeat with B=0x0000, Cin=1 -> same result.
- **Signed overflow:** A=0x7FFF, B=0x0000, Cin=1 -> Sum=0x8000, Cout=0, Ovf=1. Then A=0x8000, B=0x8000 -> Sum=0x0000, Cout=1, Ovf=1.
- **Accumulate chain:**
  - AccClr=1 + InValid + AccEn=1, A=0x0010 -> Sum=Acc=0x0010.
  - Then AccEn=1, A=0x0020, B=0xFFFF -> Sum=Acc=0x0030 (B ignored).
  - Then AccEn=0, A=1, B=1 -> Sum=0x0002, Acc stays 0x0030.
- **Backpressure:** OutReady=0 for 5 cycles in HOLD while InValid=1 and AccClr=1 -> OutValid held, Sum/Acc unchanged, InReady=0, nothing captured. OutReady=1 -> IDLE next edge, InReady=1.
- **Reset mid-operation:** Rst_n pulsed low after 2 ADD cycles of A=0xFFFF, B=0x0001 -> Sum=0, Acc=0, Cout=0, Ovf=0, OutValid=0 asynchronously. Next op A=0x0003, B=0x0004 -> Sum=0x0007.
